mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 8'd255: max cycles a grant waits for mem_ready before abort.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_req  in  1  fetch request, held while stalled.
REQ-005 i_addr  in  32  fetch address.
REQ-006 i_rdata  out  32  fetched word, registered.
REQ-007 i_stall  out  1  fetch not yet served.
REQ-008 d_req  in  1  data request (load or store), held while stalled.
REQ-009 d_we  in  1  1 = store.
REQ-010 d_addr  in  32  data address.
REQ-011 d_wdata  in  32  store data.
REQ-012 d_rdata  out  32  loaded word, registered.
REQ-013 d_stall  out  1  data access not yet served.
REQ-014 mem_req  out  1  request to the single shared memory port.
REQ-015 mem_we  out  1  write strobe to memory.
REQ-016 mem_addr  out  32  memory address.
REQ-017 mem_wdata  out  32  memory write data.
REQ-018 mem_rdata  in  32  memory read data, valid with mem_ready.
REQ-019 mem_ready  in  1  memory completes the access this cycle.
REQ-020 bus_err  out  1  sticky: an access timed out.

Function
REQ-021 FSM states IDLE, IBUSY, DBUSY; one memory access outstanding at a time.
REQ-022 Flags i_srv and d_srv mark a request served for the current pipeline step.
REQ-023 i_stall = i_req & ~i_srv; d_stall = d_req & ~d_srv; both combinational.
REQ-024 Advance = ~i_stall & ~d_stall; at an advancing edge i_srv and d_srv clear to 0.
REQ-025 IDLE: if d_req & ~d_srv, go to DBUSY; else if i_req & ~i_srv, go to IBUSY. D has priority as the older instruction.
REQ-026 On grant, latch addr/we/wdata into output registers (mem_we = 0 for I-side); mem_req = 1 for every cycle in xBUSY; outputs stay stable until completion.
REQ-027 In xBUSY with mem_ready = 1: load mem_rdata into x_rdata (d_rdata unchanged for a store); set x_srv; return to IDLE.
REQ-028 mem_ready outside xBUSY is ignored.
REQ-029 Minimum latency is 2 cycles from request to stall deassert: IDLE edge, then a BUSY cycle with mem_ready.
REQ-030 Simultaneous requests are served D then I; total stall is at least 4 cycles.
REQ-031 The served flag prevents a completed store from re-issuing while the other side still stalls.
REQ-032 An 8-bit wait counter clears on grant and increments each xBUSY cycle without mem_ready.
REQ-033 When the counter reaches TIMEOUT: treat as complete, x_rdata = 0, set x_srv, set bus_err, go to IDLE.
REQ-034 bus_err is cleared only by rst.
REQ-035 A request dropped while in IDLE (not yet granted) is not issued; once granted, the access always completes.

Reset
REQ-036 On rst: state = IDLE, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, i_rdata = 0, d_rdata = 0, i_srv = 0, d_srv = 0, counter = 0, bus_err = 0.
REQ-037 rst during xBUSY drops mem_req in the next cycle; the in-flight result is discarded.

Verification
REQ-038 i_req = 1, i_addr = 0x40; mem_ready one cycle after mem_req with rdata 0x20080005 -> mem_addr = 0x40, mem_we = 0, i_rdata = 0x20080005, i_stall low 2 cycles after request.
REQ-039 i_req and d_req (store, d_addr = 0x10, wdata = 0xAB) in the same cycle -> store issued first with mem_we = 1, then fetch; d_stall drops after the store; no second store while i_stall = 1.
REQ-040 Load 0x14 with mem_ready delayed 5 cycles -> mem_req and mem_addr held stable 6 cycles, d_rdata = mem_rdata, counter never reaches TIMEOUT.
REQ-041 mem_ready tied 0, TIMEOUT = 8 -> abort after 8 busy cycles, d_rdata = 0, bus_err = 1 and held until rst.
REQ-042 rst asserted mid-DBUSY -> next cycle mem_req = 0, all outputs at reset values, next request arbitrated normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch side and a
// data (load/store) side. Only one access is outstanding at a time. Data wins
// ties because it belongs to the older instruction. A wait counter aborts an
// access that the memory never completes.
module mem_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        r_iSrv;
    logic        r_dSrv;
    logic [7:0]  r_cnt;
    logic        r_memWe;
    logic [31:0] r_memAddr;
    logic [31:0] r_memWdata;
    logic [31:0] r_iRdata;
    logic [31:0] r_dRdata;
    logic        r_busErr;

    logic        w_iStall;
    logic        w_dStall;
    logic        w_advance;
    logic        w_busy;
    logic [7:0]  w_cntNext;
    logic        w_grantI;
    logic        w_grantD;
    logic        w_complete;
    logic        w_timeout;
    logic        w_finish;

    // A side stalls until its request has been served in this pipeline step;
    // the pipeline advances only when neither side stalls.
    assign w_iStall  = i_req & ~r_iSrv;
    assign w_dStall  = d_req & ~r_dSrv;
    assign w_advance = ~w_iStall & ~w_dStall;
    assign w_busy    = (r_state != IDLE);
    assign w_cntNext = r_cnt + 8'd1;
    assign w_finish  = w_complete | w_timeout;

    assign i_stall   = w_iStall;
    assign d_stall   = w_dStall;
    assign mem_req   = w_busy;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign i_rdata   = r_iRdata;
    assign d_rdata   = r_dRdata;
    assign bus_err   = r_busErr;

    // State register; reset always returns to IDLE, discarding any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Arbitration and completion decode: data side first, abort when the wait
    // counter would reach TIMEOUT on a cycle without mem_ready.
    always_comb begin
        w_nextState = r_state;
        w_grantI    = 1'b0;
        w_grantD    = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (d_req && !r_dSrv) begin
                    w_grantD    = 1'b1;
                    w_nextState = DBUSY;
                end else if (i_req && !r_iSrv) begin
                    w_grantI    = 1'b1;
                    w_nextState = IBUSY;
                end
            end
            IBUSY, DBUSY: begin
                if (mem_ready) begin
                    w_complete  = 1'b1;
                    w_nextState = IDLE;
                end else if (w_cntNext == TIMEOUT) begin
                    w_timeout   = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: latch the granted request onto the memory port, capture read
    // data, maintain served flags, wait counter and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iSrv     <= 1'b0;
            r_dSrv     <= 1'b0;
            r_cnt      <= 8'd0;
            r_memWe    <= 1'b0;
            r_memAddr  <= 32'd0;
            r_memWdata <= 32'd0;
            r_iRdata   <= 32'd0;
            r_dRdata   <= 32'd0;
            r_busErr   <= 1'b0;
        end else begin
            if (w_grantD) begin
                r_memWe    <= d_we;
                r_memAddr  <= d_addr;
                r_memWdata <= d_wdata;
                r_cnt      <= 8'd0;
            end else if (w_grantI) begin
                r_memWe    <= 1'b0;
                r_memAddr  <= i_addr;
                r_cnt      <= 8'd0;
            end else if (w_busy && !mem_ready) begin
                r_cnt      <= w_cntNext;
            end

            if (w_complete && r_state == IBUSY) begin
                r_iRdata <= mem_rdata;
            end
            if (w_complete && r_state == DBUSY && !r_memWe) begin
                r_dRdata <= mem_rdata;
            end
            if (w_timeout) begin
                r_busErr <= 1'b1;
                if (r_state == IBUSY) begin
                    r_iRdata <= 32'd0;
                end else begin
                    r_dRdata <= 32'd0;
                end
            end

            if (w_advance) begin
                r_iSrv <= 1'b0;
                r_dSrv <= 1'b0;
            end
            if (w_finish && r_state == IBUSY) begin
                r_iSrv <= i_req;
            end
            if (w_finish && r_state == DBUSY) begin
                r_dSrv <= d_req;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter with a small
// memory responder and hand-written sequences for multi-cycle corner cases.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_err;

    int checks;
    int errors;

    typedef struct {
        bit          isData;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] memData;
        logic [31:0] expRdata;
        int          expLat;
        int          expBusy;
        bit          expBusErr;
    } vec_t;

    vec_t vectors[10];

    mem_arbiter #(.TIMEOUT(8'd8)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_stall   (i_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_err   (bus_err)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one vector, plays the memory with the requested delay and checks
    // latency, the memory port contents and the returned data.
    task automatic applyStimulus(input int idx);
        vec_t        v;
        int          lat;
        int          busy;
        bit          done;
        bit          stable;
        logic [31:0] seenAddr;
        logic [31:0] seenWdata;
        logic        seenWe;
        logic        stallNow;
        v         = vectors[idx];
        lat       = 0;
        busy      = 0;
        done      = 1'b0;
        stable    = 1'b1;
        seenAddr  = 32'd0;
        seenWdata = 32'd0;
        seenWe    = 1'b0;
        @(negedge clk);
        if (v.isData) begin
            d_req   = 1'b1;
            d_we    = v.we;
            d_addr  = v.addr;
            d_wdata = v.wdata;
        end else begin
            i_req  = 1'b1;
            i_addr = v.addr;
        end
        mem_ready = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            stallNow = v.isData ? d_stall : i_stall;
            if (!stallNow) begin
                done      = 1'b1;
                mem_ready = 1'b0;
            end else if (mem_req) begin
                if (busy == 0) begin
                    seenAddr  = mem_addr;
                    seenWe    = mem_we;
                    seenWdata = mem_wdata;
                end else if (mem_addr !== seenAddr || mem_we !== seenWe || mem_wdata !== seenWdata) begin
                    stable = 1'b0;
                end
                mem_ready = (busy == v.delay);
                mem_rdata = (busy == v.delay) ? v.memData : 32'hDEADBEEF;
                busy++;
            end else begin
                mem_ready = 1'b0;
            end
        end
        checkOutput($sformatf("v%0d.done", idx), 32'(done), 32'd1);
        checkOutput($sformatf("v%0d.latency", idx), 32'(lat), 32'(v.expLat));
        checkOutput($sformatf("v%0d.busyCycles", idx), 32'(busy), 32'(v.expBusy));
        checkOutput($sformatf("v%0d.memAddr", idx), seenAddr, v.addr);
        checkOutput($sformatf("v%0d.memWe", idx), 32'(seenWe), 32'(v.isData & v.we));
        if (v.isData && v.we) begin
            checkOutput($sformatf("v%0d.memWdata", idx), seenWdata, v.wdata);
        end
        checkOutput($sformatf("v%0d.portStable", idx), 32'(stable), 32'd1);
        checkOutput($sformatf("v%0d.rdata", idx), v.isData ? d_rdata : i_rdata, v.expRdata);
        checkOutput($sformatf("v%0d.busErr", idx), 32'(bus_err), 32'(v.expBusErr));
        checkOutput($sformatf("v%0d.memReqIdle", idx), 32'(mem_req), 32'd0);
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    // Simultaneous store and fetch: store first, fetch second, no store re-issue.
    task automatic simultaneousSeq();
        int          nAcc;
        int          dDrop;
        int          iDrop;
        logic        prevReq;
        logic [31:0] accAddr[3];
        logic        accWe[3];
        logic [31:0] accWdata[3];
        logic [31:0] dBefore;
        nAcc    = 0;
        dDrop   = -1;
        iDrop   = -1;
        prevReq = 1'b0;
        for (int k = 0; k < 3; k++) begin
            accAddr[k]  = 32'd0;
            accWe[k]    = 1'b0;
            accWdata[k] = 32'd0;
        end
        @(negedge clk);
        dBefore = 32'h55AA55AA;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h10;
        d_wdata = 32'hAB;
        i_req   = 1'b1;
        i_addr  = 32'h48;
        for (int c = 1; c <= 12 && iDrop < 0; c++) begin
            @(negedge clk);
            if (!d_stall && dDrop < 0) dDrop = c;
            if (!i_stall) iDrop = c;
            if (mem_req && !prevReq) begin
                if (nAcc < 3) begin
                    accAddr[nAcc]  = mem_addr;
                    accWe[nAcc]    = mem_we;
                    accWdata[nAcc] = mem_wdata;
                end
                nAcc++;
            end
            prevReq   = mem_req;
            mem_ready = mem_req;
            mem_rdata = mem_req ? 32'h11112222 : 32'd0;
        end
        i_req     = 1'b0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_req && !prevReq) nAcc++;
            prevReq = mem_req;
        end
        checkOutput("sim.accessCount", 32'(nAcc), 32'd2);
        checkOutput("sim.firstWe", 32'(accWe[0]), 32'd1);
        checkOutput("sim.firstAddr", accAddr[0], 32'h10);
        checkOutput("sim.firstWdata", accWdata[0], 32'hAB);
        checkOutput("sim.secondWe", 32'(accWe[1]), 32'd0);
        checkOutput("sim.secondAddr", accAddr[1], 32'h48);
        checkOutput("sim.dStallDrop", 32'(dDrop), 32'd2);
        checkOutput("sim.iStallDrop", 32'(iDrop), 32'd4);
        checkOutput("sim.iRdata", i_rdata, 32'h11112222);
        checkOutput("sim.dRdataKept", d_rdata, dBefore);
    endtask

    // Reset asserted while a load is stuck in DBUSY.
    task automatic resetMidBusySeq();
        @(negedge clk);
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h60;
        d_wdata   = 32'h13572468;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstSeq.busyReq", 32'(mem_req), 32'd1);
        checkOutput("rstSeq.busyAddr", mem_addr, 32'h60);
        rst   = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        checkOutput("rstSeq.memReq", 32'(mem_req), 32'd0);
        checkOutput("rstSeq.memAddr", mem_addr, 32'd0);
        checkOutput("rstSeq.memWdata", mem_wdata, 32'd0);
        checkOutput("rstSeq.iRdata", i_rdata, 32'd0);
        checkOutput("rstSeq.dRdata", d_rdata, 32'd0);
        checkOutput("rstSeq.busErr", 32'(bus_err), 32'd0);
        rst = 1'b0;
    endtask

    // Main sequence: reset, vector table, then the multi-cycle corner cases.
    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        i_req     = 1'b0;
        i_addr    = 32'd0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 32'd0;
        d_wdata   = 32'd0;
        mem_rdata = 32'd0;
        mem_ready = 1'b0;

        vectors[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        0,  32'h20080005, 32'h20080005, 2, 1, 1'b0};
        vectors[1] = '{1'b1, 1'b0, 32'h14,  32'h0,        5,  32'h12345678, 32'h12345678, 7, 6, 1'b0};
        vectors[2] = '{1'b1, 1'b1, 32'h10,  32'hAB,       0,  32'hFEEDFACE, 32'h12345678, 2, 1, 1'b0};
        vectors[3] = '{1'b0, 1'b0, 32'h44,  32'h0,        2,  32'hCAFEF00D, 32'hCAFEF00D, 4, 3, 1'b0};
        vectors[4] = '{1'b1, 1'b0, 32'h20,  32'h0,        1,  32'h0BADF00D, 32'h0BADF00D, 3, 2, 1'b0};
        vectors[5] = '{1'b1, 1'b0, 32'h24,  32'h0,        7,  32'h55AA55AA, 32'h55AA55AA, 9, 8, 1'b0};
        vectors[6] = '{1'b1, 1'b0, 32'h30,  32'h0,        99, 32'h44444444, 32'h00000000, 9, 8, 1'b1};
        vectors[7] = '{1'b0, 1'b0, 32'h80,  32'h0,        1,  32'h0000BEEF, 32'h0000BEEF, 3, 2, 1'b1};
        vectors[8] = '{1'b1, 1'b0, 32'h84,  32'hFFFF0000, 0,  32'h77778888, 32'h77778888, 2, 1, 1'b1};
        vectors[9] = '{1'b0, 1'b0, 32'h100, 32'h0,        0,  32'h9ABCDEF0, 32'h9ABCDEF0, 2, 1, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset.memReq", 32'(mem_req), 32'd0);
        checkOutput("reset.memWe", 32'(mem_we), 32'd0);
        checkOutput("reset.memAddr", mem_addr, 32'd0);
        checkOutput("reset.memWdata", mem_wdata, 32'd0);
        checkOutput("reset.iRdata", i_rdata, 32'd0);
        checkOutput("reset.dRdata", d_rdata, 32'd0);
        checkOutput("reset.busErr", 32'(bus_err), 32'd0);
        checkOutput("reset.iStall", 32'(i_stall), 32'd0);
        checkOutput("reset.dStall", 32'(d_stall), 32'd0);

        mem_ready = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        mem_ready = 1'b0;
        checkOutput("idleReady.memReq", 32'(mem_req), 32'd0);
        checkOutput("idleReady.iRdata", i_rdata, 32'd0);
        checkOutput("idleReady.dRdata", d_rdata, 32'd0);

        for (int k = 0; k <= 5; k++) applyStimulus(k);
        simultaneousSeq();
        applyStimulus(6);
        repeat (4) @(negedge clk);
        checkOutput("busErr.sticky", 32'(bus_err), 32'd1);
        for (int k = 7; k <= 8; k++) applyStimulus(k);
        resetMidBusySeq();
        applyStimulus(9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
